// File: rtl/tboom_rename_pkg.sv
// Shared rename-stage definitions: checkpoint FSM states and the default
// checkpoint depth used by the map table, freelist and checkpoint controller.
package tboom_rename_pkg;

  localparam int DEFAULT_CHECKPOINT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    RECOVER = 2'd2
  } ckpt_state_e;

endpackage

// File: rtl/tboom_checkpoint_ctrl_if.sv
// Branch-allocation, resolve and rename-unit control bundle of the checkpoint
// controller. The slave modport is the controller, the master its environment.
interface tboom_checkpoint_ctrl_if
  import tboom_rename_pkg::*;
#(
  parameter int CHECKPOINT_DEPTH = DEFAULT_CHECKPOINT_DEPTH,
  parameter int TAG_WIDTH        = $clog2(CHECKPOINT_DEPTH)
);

  logic                        br_alloc_valid;
  logic                        br_alloc_ready;
  logic [TAG_WIDTH-1:0]        br_alloc_tag;
  logic                        resolve_valid;
  logic [TAG_WIDTH-1:0]        resolve_tag;
  logic                        resolve_mispredict;
  logic                        checkpoint;
  logic                        restore;
  logic [TAG_WIDTH-1:0]        checkpoint_restore_pos;
  logic                        rename_stall;
  logic [CHECKPOINT_DEPTH-1:0] busy_mask;
  logic [TAG_WIDTH:0]          busy_count;

  modport master (
    output br_alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    input  br_alloc_ready, br_alloc_tag, checkpoint, restore,
           checkpoint_restore_pos, rename_stall, busy_mask, busy_count
  );

  modport slave (
    input  br_alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    output br_alloc_ready, br_alloc_tag, checkpoint, restore,
           checkpoint_restore_pos, rename_stall, busy_mask, busy_count
  );

endinterface

// File: rtl/tboom_squash_mask_gen.sv
// Combinational circular range mask [start, end) over the checkpoint ring.
// When start equals end the ring is either wholly live (full_i) or empty.
module tboom_squash_mask_gen #(
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = $clog2(DEPTH)
) (
  input  logic [TAG_WIDTH-1:0] start_tag_i,
  input  logic [TAG_WIDTH-1:0] end_tag_i,
  input  logic                 full_i,
  output logic [DEPTH-1:0]     mask_o
);

  logic [TAG_WIDTH-1:0] span;

  // Slot i is inside the range when its distance from start, taken modulo
  // the ring size, is smaller than the range length.
  always_comb begin
    span   = end_tag_i - start_tag_i;
    mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (start_tag_i == end_tag_i) begin
        mask_o[i] = full_i;
      end else begin
        mask_o[i] = (TAG_WIDTH'(i) - start_tag_i) < span;
      end
    end
  end

endmodule

// File: rtl/tboom_checkpoint_ctrl.sv
// Checkpoint/branch-tag controller for the two-wide rename stage.
// Optional performance counters are enabled by defining TBOOM_CKPT_PERF_EN.
module tboom_checkpoint_ctrl
  import tboom_rename_pkg::*;
#(
  parameter int CHECKPOINT_DEPTH = DEFAULT_CHECKPOINT_DEPTH,
  parameter int TAG_WIDTH        = $clog2(CHECKPOINT_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TBOOM_CKPT_PERF_EN
  output logic [31:0] perf_mispredicts,
  output logic [31:0] perf_full_stall_cycles,
`endif
  tboom_checkpoint_ctrl_if.slave ckpt_if
);

  logic [CHECKPOINT_DEPTH-1:0] busy_q, busy_d;
  logic [TAG_WIDTH-1:0]        tail_q, tail_d;
  logic [TAG_WIDTH-1:0]        restore_tag_q, restore_tag_d;
  ckpt_state_e                 state_q, state_d;

  logic [CHECKPOINT_DEPTH-1:0] squash_mask;
  logic                        tag_live;
  logic                        mispredict_accept;
  logic                        correct_accept;
  logic                        alloc_ready;
  logic                        alloc_fire;
  logic [TAG_WIDTH:0]          live_count;

  assign tag_live          = busy_q[ckpt_if.resolve_tag];
  assign mispredict_accept = ckpt_if.resolve_valid &&  ckpt_if.resolve_mispredict && tag_live;
  assign correct_accept    = ckpt_if.resolve_valid && !ckpt_if.resolve_mispredict && tag_live;
  assign alloc_ready       = !busy_q[tail_q] && (state_q == IDLE) && !mispredict_accept;
  assign alloc_fire        = ckpt_if.br_alloc_valid && alloc_ready;

  // A live tail slot means the ring has wrapped onto the oldest branch, so a
  // mispredict at tag == tail squashes every slot rather than none.
  tboom_squash_mask_gen #(
    .DEPTH    (CHECKPOINT_DEPTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_squash_mask_gen (
    .start_tag_i(ckpt_if.resolve_tag),
    .end_tag_i  (tail_q),
    .full_i     (busy_q[tail_q]),
    .mask_o     (squash_mask)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    busy_d        = busy_q;
    tail_d        = tail_q;
    restore_tag_d = restore_tag_q;
    state_d       = state_q;

    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      tail_d         = tail_q + TAG_WIDTH'(1);
    end
    if (correct_accept) begin
      busy_d[ckpt_if.resolve_tag] = 1'b0;
    end

    unique case (state_q)
      IDLE:    state_d = IDLE;
      RESTORE: state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (mispredict_accept) begin
      busy_d        = busy_q & ~squash_mask;
      tail_d        = ckpt_if.resolve_tag;
      restore_tag_d = ckpt_if.resolve_tag;
      state_d       = RESTORE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      tail_q        <= '0;
      restore_tag_q <= '0;
      state_q       <= IDLE;
    end else begin
      busy_q        <= busy_d;
      tail_q        <= tail_d;
      restore_tag_q <= restore_tag_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    live_count = '0;
    for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
      live_count = live_count + (TAG_WIDTH + 1)'(busy_q[i]);
    end
  end

  assign ckpt_if.br_alloc_ready         = alloc_ready;
  assign ckpt_if.br_alloc_tag           = tail_q;
  assign ckpt_if.checkpoint             = alloc_fire;
  assign ckpt_if.restore                = (state_q == RESTORE);
  assign ckpt_if.checkpoint_restore_pos = (state_q == RESTORE) ? restore_tag_q : tail_q;
  assign ckpt_if.rename_stall           = (state_q != IDLE);
  assign ckpt_if.busy_mask              = busy_q;
  assign ckpt_if.busy_count             = live_count;

`ifdef TBOOM_CKPT_PERF_EN
  logic [31:0] perf_mispredicts_q;
  logic [31:0] perf_full_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mispredicts_q <= '0;
      perf_full_stall_q  <= '0;
    end else begin
      if (mispredict_accept) begin
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
      if (ckpt_if.br_alloc_valid && (state_q == IDLE) && busy_q[tail_q]) begin
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
      end
    end
  end

  assign perf_mispredicts       = perf_mispredicts_q;
  assign perf_full_stall_cycles = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_tboom_checkpoint_ctrl.sv
// Self-checking bench for tboom_checkpoint_ctrl: a slot-ring reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_tboom_checkpoint_ctrl;

  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  tboom_checkpoint_ctrl_if #(.CHECKPOINT_DEPTH(DEPTH), .TAG_WIDTH(TW)) ckpt_if ();

`ifdef TBOOM_CKPT_PERF_EN
  logic [31:0] perf_mispredicts;
  logic [31:0] perf_full_stall_cycles;
`endif

  tboom_checkpoint_ctrl #(.CHECKPOINT_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk                   (clk),
    .rst                   (rst),
`ifdef TBOOM_CKPT_PERF_EN
    .perf_mispredicts      (perf_mispredicts),
    .perf_full_stall_cycles(perf_full_stall_cycles),
`endif
    .ckpt_if               (ckpt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: live bits per slot, next slot to hand out, and the number
  // of stall cycles still owed after the last accepted mispredict (2 = restore
  // cycle, 1 = recover cycle, 0 = free running).
  bit          m_busy [DEPTH];
  int          m_tail;
  int          m_stall_left;
  int          m_restore_tag;
  int unsigned m_perf_mis;
  int unsigned m_perf_full;
  bit          model_ok = 1'b0;

  function automatic bit m_is_mispredict();
    return ckpt_if.resolve_valid && ckpt_if.resolve_mispredict
           && m_busy[int'(ckpt_if.resolve_tag)];
  endfunction

  function automatic bit m_can_alloc();
    return !m_busy[m_tail] && (m_stall_left == 0) && !m_is_mispredict();
  endfunction

  always @(posedge clk) begin
    bit mis, cor, alloc, full_stall;
    int t;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_tail        = 0;
      m_stall_left  = 0;
      m_restore_tag = 0;
      m_perf_mis    = 0;
      m_perf_full   = 0;
      model_ok      = 1'b1;
    end else if (model_ok) begin
      t          = int'(ckpt_if.resolve_tag);
      mis        = m_is_mispredict();
      cor        = ckpt_if.resolve_valid && !ckpt_if.resolve_mispredict && m_busy[t];
      alloc      = ckpt_if.br_alloc_valid && m_can_alloc();
      full_stall = ckpt_if.br_alloc_valid && (m_stall_left == 0) && m_busy[m_tail];
      if (full_stall) m_perf_full++;
      if (cor) m_busy[t] = 1'b0;
      if (alloc) begin
        m_busy[m_tail] = 1'b1;
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (m_stall_left > 0) m_stall_left--;
      if (mis) begin
        // Walk from the mispredicted slot toward the youngest; a wrapped ring
        // (tag == tail) walks all the way around.
        do begin
          m_busy[t] = 1'b0;
          t = (t + 1) % DEPTH;
        end while (t != m_tail);
        m_tail        = int'(ckpt_if.resolve_tag);
        m_restore_tag = m_tail;
        m_stall_left  = 2;
        m_perf_mis++;
      end
    end
  end

  always @(negedge clk) begin
    logic [DEPTH-1:0] exp_mask;
    int               exp_count;
    bit               exp_ready, exp_ckpt, exp_restore;
    if (model_ok) begin
      exp_count = 0;
      for (int i = 0; i < DEPTH; i++) begin
        exp_mask[i] = m_busy[i];
        exp_count  += int'(m_busy[i]);
      end
      exp_ready   = m_can_alloc();
      exp_ckpt    = ckpt_if.br_alloc_valid && exp_ready;
      exp_restore = (m_stall_left == 2);
      check("busy_mask",    ckpt_if.busy_mask,      exp_mask);
      check("busy_count",   ckpt_if.busy_count,     exp_count);
      check("ready",        ckpt_if.br_alloc_ready, exp_ready);
      check("checkpoint",   ckpt_if.checkpoint,     exp_ckpt);
      check("restore",      ckpt_if.restore,        exp_restore);
      check("rename_stall", ckpt_if.rename_stall,   m_stall_left > 0);
      if (exp_restore) check("restore_pos", ckpt_if.checkpoint_restore_pos, m_restore_tag);
      if (exp_ckpt) begin
        check("ckpt_pos",  ckpt_if.checkpoint_restore_pos, m_tail);
        check("alloc_tag", ckpt_if.br_alloc_tag,           m_tail);
      end
`ifdef TBOOM_CKPT_PERF_EN
      check("perf_mispredicts", perf_mispredicts,       m_perf_mis);
      check("perf_full_stall",  perf_full_stall_cycles, m_perf_full);
`endif
    end
  end

  // Drive one cycle of inputs from just after an edge, then return to idle
  // inputs just after the following edge.
  task automatic cyc(input bit av, input bit rv, input int rt, input bit rm);
    ckpt_if.br_alloc_valid     = av;
    ckpt_if.resolve_valid      = rv;
    ckpt_if.resolve_tag        = TW'(rt);
    ckpt_if.resolve_mispredict = rm;
    @(posedge clk);
    #1;
    ckpt_if.br_alloc_valid     = 1'b0;
    ckpt_if.resolve_valid      = 1'b0;
    ckpt_if.resolve_tag        = '0;
    ckpt_if.resolve_mispredict = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic alloc(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    ckpt_if.br_alloc_valid     = 1'b0;
    ckpt_if.resolve_valid      = 1'b0;
    ckpt_if.resolve_tag        = '0;
    ckpt_if.resolve_mispredict = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    check("rst_count",   ckpt_if.busy_count,     0);
    check("rst_ready",   ckpt_if.br_alloc_ready, 1);
    check("rst_restore", ckpt_if.restore,        0);
    check("rst_stall",   ckpt_if.rename_stall,   0);
    check("rst_ckpt",    ckpt_if.checkpoint,     0);

    // Three consecutive grants.
    alloc(3);
    check("three_mask",  ckpt_if.busy_mask,  8'h07);
    check("three_count", ckpt_if.busy_count, 3);

    // Tags 0..5 live, mispredict tag 2.
    alloc(3);
    check("six_mask", ckpt_if.busy_mask, 8'h3f);
    cyc(0, 1, 2, 1);
    check("mp_restore",   ckpt_if.restore,                1);
    check("mp_pos",       ckpt_if.checkpoint_restore_pos, 2);
    check("mp_stall1",    ckpt_if.rename_stall,           1);
    check("mp_mask",      ckpt_if.busy_mask,              8'h03);
    idle(1);
    check("mp_stall2",    ckpt_if.rename_stall,           1);
    check("mp_restore2",  ckpt_if.restore,                0);
    check("mp_ready2",    ckpt_if.br_alloc_ready,         0);
    idle(1);
    check("mp_stall3",    ckpt_if.rename_stall,           0);
    check("mp_ready3",    ckpt_if.br_alloc_ready,         1);
    check("mp_next_tag",  ckpt_if.br_alloc_tag,           2);

    // Nested mispredict arriving during the restore cycle.
    alloc(4);
    check("nest_mask0", ckpt_if.busy_mask, 8'h3f);
    cyc(0, 1, 4, 1);
    cyc(0, 1, 1, 1);
    check("nest_restore", ckpt_if.restore,                1);
    check("nest_pos",     ckpt_if.checkpoint_restore_pos, 1);
    check("nest_mask",    ckpt_if.busy_mask,              8'h01);
    idle(1);
    check("nest_stall2",  ckpt_if.rename_stall,           1);
    check("nest_rest2",   ckpt_if.restore,                0);
    idle(1);
    check("nest_stall3",  ckpt_if.rename_stall,           0);

    // Resolves against squashed or free tags change nothing.
    cyc(0, 1, 4, 0);
    check("stale_mask", ckpt_if.busy_mask, 8'h01);
    cyc(0, 1, 4, 1);
    check("free_mp_restore", ckpt_if.restore,      0);
    check("free_mp_stall",   ckpt_if.rename_stall, 0);
    check("free_mp_mask",    ckpt_if.busy_mask,    8'h01);

    // Fill the ring, free out of order, then wrap.
    do_reset();
    alloc(8);
    check("full_mask",  ckpt_if.busy_mask,      8'hff);
    check("full_count", ckpt_if.busy_count,     8);
    check("full_ready", ckpt_if.br_alloc_ready, 0);
    cyc(1, 1, 3, 0);
    check("free3_mask",  ckpt_if.busy_mask,      8'hf7);
    check("free3_ready", ckpt_if.br_alloc_ready, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 2, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("wrap_mask",  ckpt_if.busy_mask,      8'hff);
    check("wrap_ready", ckpt_if.br_alloc_ready, 0);
    check("wrap_tail",  ckpt_if.br_alloc_tag,   4);

    // Mispredict on the oldest slot of a full ring clears everything.
    cyc(0, 1, 4, 1);
    check("allclr_mask", ckpt_if.busy_mask, 8'h00);
    check("allclr_pos",  ckpt_if.checkpoint_restore_pos, 4);
    idle(2);

    // Reset during the recover cycle.
    do_reset();
    alloc(6);
    cyc(0, 1, 5, 1);
    idle(1);
    check("rec_mask",  ckpt_if.busy_mask,    8'h1f);
    check("rec_stall", ckpt_if.rename_stall, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rr_mask",    ckpt_if.busy_mask,    8'h00);
    check("rr_stall",   ckpt_if.rename_stall, 0);
    check("rr_tag",     ckpt_if.br_alloc_tag, 0);
    check("rr_restore", ckpt_if.restore,      0);
`ifdef TBOOM_CKPT_PERF_EN
    check("rr_perf_mis",  perf_mispredicts,       0);
    check("rr_perf_full", perf_full_stall_cycles, 0);
`endif
    idle(1);
    check("rr_restore2", ckpt_if.restore, 0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(499) == 0);
      cyc($urandom_range(99) < 70, $urandom_range(99) < 45,
          int'($urandom_range(DEPTH - 1)), $urandom_range(99) < 20);
    end
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
